// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared receiver state encoding and parity constants
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // ones_odd is the XOR over data plus the received parity bit
  function automatic logic parity_bad(input int mode, input logic ones_odd);
    return (mode == PARITY_ODD) ? ~ones_odd : ones_odd;
  endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// rtl/rx_byte_fifo.sv - first-word-fall-through receive FIFO, power-of-two depth
module rx_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = r_count[AW];
  assign w_pop   = i_rd_en & ~o_empty;
  // A pop frees the slot this same cycle, so a full FIFO can still accept
  assign w_push  = i_wr_en & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver feeding a byte FIFO with sticky error flags
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int BAUD_VAL   = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [DATA_BITS-1:0]          data,
  output logic                          data_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          busy
);

  localparam logic [15:0] CNT_FULL = 16'(BAUD_VAL - 1);
  localparam logic [15:0] CNT_HALF = 16'(BAUD_VAL / 2 - 1);

  rx_state_t              r_state;
  rx_state_t              w_next_state;
  logic                   r_rx_meta;
  logic                   r_rx_sync;
  logic                   r_rx_prev;
  logic [1:0]             r_sync_fill;
  logic [15:0]            r_cnt;
  logic [3:0]             r_bit_idx;
  logic                   r_stop_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_bad;
  logic                   r_stop_bad;
  logic                   r_frame_err;
  logic                   r_parity_err;
  logic                   r_overrun;

  logic w_fall;
  logic w_tick;
  logic w_last_bit;
  logic w_last_stop;
  logic w_frame_done;
  logic w_stop_bad;
  logic w_good;
  logic w_frame_err_set;
  logic w_parity_err_set;
  logic w_overrun_set;
  logic w_fifo_full;
  logic w_fifo_empty;

  // r_sync_fill marks when r_rx_sync holds a real line sample; a line
  // already low at reset release must not look like a falling edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b0;
      r_sync_fill <= 2'b00;
    end else begin
      r_rx_meta   <= rx;
      r_rx_sync   <= r_rx_meta;
      r_sync_fill <= {r_sync_fill[0], 1'b1};
      r_rx_prev   <= r_rx_sync & r_sync_fill[1];
    end
  end

  assign w_fall      = r_sync_fill[1] & r_rx_prev & ~r_rx_sync;
  assign w_tick      = (r_cnt == '0);
  assign w_last_bit  = (r_bit_idx == 4'(DATA_BITS - 1));
  assign w_last_stop = (STOP_BITS == 1) | r_stop_idx;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_fall) w_next_state = ST_START;
      ST_START: if (w_tick) w_next_state = r_rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_tick && w_last_bit)
                  w_next_state = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
      ST_PAR:   if (w_tick) w_next_state = ST_STOP;
      ST_STOP:  if (w_tick && w_last_stop) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy             = (r_state != ST_IDLE);
    w_frame_done     = (r_state == ST_STOP) & w_tick & w_last_stop;
    w_stop_bad       = r_stop_bad | ~r_rx_sync;
    w_good           = w_frame_done & ~w_stop_bad & ~r_par_bad;
    w_frame_err_set  = w_frame_done & w_stop_bad;
    w_parity_err_set = w_frame_done & r_par_bad;
    w_overrun_set    = w_good & w_fifo_full & ~rd_en;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_par_bad  <= 1'b0;
      r_stop_bad <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par_bad  <= 1'b0;
      r_stop_bad <= 1'b0;
      if (w_fall) r_cnt <= CNT_HALF;
    end else begin
      r_cnt <= w_tick ? CNT_FULL : r_cnt - 1'b1;
      if (w_tick) begin
        case (r_state)
          ST_DATA: begin
            r_shift   <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
          end
          ST_PAR:  r_par_bad <= parity_bad(PARITY, ^{r_rx_sync, r_shift});
          ST_STOP: begin
            r_stop_bad <= w_stop_bad;
            r_stop_idx <= ~r_stop_idx;
          end
          default: r_bit_idx <= '0;
        endcase
      end
    end
  end

  // A flag-setting event outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_frame_err_set)  r_frame_err  <= 1'b1;
      else if (err_clr)     r_frame_err  <= 1'b0;
      if (w_parity_err_set) r_parity_err <= 1'b1;
      else if (err_clr)     r_parity_err <= 1'b0;
      if (w_overrun_set)    r_overrun    <= 1'b1;
      else if (err_clr)     r_overrun    <= 1'b0;
    end
  end

  rx_byte_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (clk),
    .i_reset_n (reset),
    .i_wr_en   (w_good),
    .i_wr_data (r_shift),
    .i_rd_en   (rd_en),
    .o_rd_data (data),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full),
    .o_count   (fifo_count)
  );

  assign data_valid = ~w_fifo_empty;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule
